refclk_out_sel_ctrl: RTL and testbench
======================================

# refclk_out_sel_ctrl

Sequencing controller for the GT reference-clock differential output buffer's four-way recovered-clock mux. It arbitrates four channel requesters, round-robin, for ownership of the single refclk output pin pair. It drives the buffer's 2-bit select and active-low enable so that the select never changes while the output is enabled. The block sits beside the buffer in the transceiver clocking wrapper, in the same clock domain as the channel control logic.

## Interface
Parameters:
- SETTLE_CYCLES, 8: cycles CEB is held high around a select change, and after release; legal range 1..255.
- MAX_HOLD_CYCLES, 64: active cycles after which the owner is preempted if another channel is requesting. Used only when the preemption feature is compiled in; legal range 1..65535.

Ports:
- CLK  in  1  controller clock; all outputs are registered on its rising edge.
- RST  in  1  reset; synchronous, active-high.
- REQ  in  4  bit i is high while channel i wants its recovered clock driven out. Level-sensitive.
- GNT  out 4  one-hot; bit i is high only while the output buffer is enabled with the select set to i.
- RXRECCLK_SEL  out 2  buffer mux select.
- CEB  out 1  buffer enable, active-low; 1 means the output is tristated.
- BUSY  out 1  high in the SEL and RELEASE states.

## Operation
- Reset values: CEB=1, GNT=0000, RXRECCLK_SEL=00, BUSY=0, state=IDLE, round-robin pointer last=3, so channel 0 has top priority first.
- States: IDLE, SEL, ACTIVE, RELEASE.
- IDLE
  - CEB=1, GNT=0.
  - If REQ≠0, pick the winner as the first set bit searching from last+1, with modulo-4 wrap.
  - Next cycle: RXRECCLK_SEL=winner, counter=SETTLE_CYCLES, go to SEL.
- SEL
  - CEB=1. The counter decrements each cycle.
  - At counter==1: go to ACTIVE, with CEB=0 and GNT[winner]=1 registered on the same edge. Set last=winner.
  - If REQ[winner] is low in any SEL cycle: abort to RELEASE. No grant is ever issued.
- ACTIVE
  - CEB=0, GNT one-hot.
  - If REQ[owner] is low: go to RELEASE.
  - REQ changes on other channels do not disturb the owner, except through preemption.
- RELEASE
  - CEB=1, GNT=0 from the first RELEASE cycle. RXRECCLK_SEL holds its value.
  - Counter=SETTLE_CYCLES; at counter==1 go to IDLE.
- RXRECCLK_SEL changes only on the IDLE→SEL edge, which guarantees CEB was high for at least SETTLE_CYCLES on both sides of every change.
- Simultaneous events:
  - If REQ[owner] drops in the same cycle that preemption fires, this is a normal release. `last` is updated identically either way.
  - If RST and any other event coincide, RST wins.
- Reset mid-operation: the next cycle shows the reset values, whatever the state was.
- Counter width is 8 bits; the hold counter is 16 bits and saturates, never wrapping.

## Timing
- A request sampled in IDLE at edge 0 gives SEL/BUSY at edge 1 and GNT/CEB=0 at edge 1+SETTLE_CYCLES. Grant latency is therefore SETTLE_CYCLES+1.
- A REQ[owner] drop sampled at edge t gives GNT=0 and CEB=1 at edge t+1, and IDLE at edge t+1+SETTLE_CYCLES.
- The earliest re-grant is 2·SETTLE_CYCLES+2 cycles after the release sample.
- No combinational path exists from inputs to outputs.

## Configuration
- REFCLK_SEL_PREEMPT_EN
  - Defined: in ACTIVE, a 16-bit hold counter counts owner cycles. When it reaches MAX_HOLD_CYCLES while (REQ & ~GNT)≠0, the block enters RELEASE. The owner's REQ is ignored until the next arbitration, which round-robin places after the other requesters.
  - Undefined: no hold counter is built. The owner keeps the output until it drops REQ, and MAX_HOLD_CYCLES is unused.

## Structure
- Package refclk_sel_pkg:
  - state enum (IDLE, SEL, ACTIVE, RELEASE)
  - NUM_CH=4
  - SEL_W=2
  - counter widths
- Sub-module rr_arb4: combinational 4-way round-robin picker. Inputs: req[3:0] and last[1:0]. Outputs: valid and idx[1:0].
- The FSM, counters and output registers live in the top.

## Test plan
All scenarios use SETTLE_CYCLES=4.
- Reset: RST high for 2 cycles, including once mid-ACTIVE → next cycle CEB=1, GNT=0000, RXRECCLK_SEL=00, BUSY=0.
- Single grant: REQ=0100 at edge 0 → RXRECCLK_SEL=10 and BUSY=1 at edges 1–4; at edge 5 CEB=0, GNT=0100, BUSY=0.
- Release: drop REQ[2] sampled at edge t → GNT=0000 and CEB=1 at t+1; IDLE at t+5. RXRECCLK_SEL stays 10 throughout.
- Round-robin: REQ=1111, each owner drops REQ for 1 cycle after 10 active cycles → grant order 0,1,2,3,0. RXRECCLK_SEL never changes while CEB=0.
- Abort: REQ=0010, drop REQ[1] at the second SEL cycle → GNT never asserted, RELEASE for 4 cycles, then IDLE.
- Preemption, MAX_HOLD_CYCLES=16, REQ=0011 held:
  - With REFCLK_SEL_PREEMPT_EN: GNT=0001 for 16 cycles, then RELEASE, then GNT=0010.
  - Without the macro: GNT=0001 indefinitely.

Source files
------------

// File: rtl/refclk_sel_pkg.sv
// ============================================================================
// refclk_sel_pkg : shared types and widths for the refclk output select ctrl
// Optional feature macro used by the top: REFCLK_SEL_PREEMPT_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

package refclk_sel_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;
  localparam int CNT_W  = 8;
  localparam int HOLD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEL     = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arb4.sv
// ============================================================================
// rr_arb4 : combinational 4-way round-robin picker, searching from last+1
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arb4
  import refclk_sel_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  last,
  output logic              valid,
  output logic [SEL_W-1:0]  idx
);

  logic [SEL_W-1:0] cand;

  // Walk from farthest to nearest so the nearest set bit after last wins.
  always_comb begin
    valid = |req;
    idx   = last;
    cand  = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = last + SEL_W'(k);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/refclk_out_sel_ctrl.sv
// ============================================================================
// refclk_out_sel_ctrl : round-robin owner sequencing for the refclk output mux
// Build macro: REFCLK_SEL_PREEMPT_EN enables hold-time preemption.
// Revision: 1.0
// ============================================================================
`default_nettype none

module refclk_out_sel_ctrl
  import refclk_sel_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES   = 8,
  parameter int unsigned MAX_HOLD_CYCLES = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] REQ,
  output logic [NUM_CH-1:0] GNT,
  output logic [SEL_W-1:0]  RXRECCLK_SEL,
  output logic              CEB,
  output logic              BUSY
);

  localparam logic [CNT_W-1:0] c_settle = CNT_W'(SETTLE_CYCLES);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    last_q, last_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [NUM_CH-1:0]   gnt_q, gnt_d;
  logic                ceb_q, ceb_d;
  logic                busy_q, busy_d;
  logic                arb_valid;
  logic [SEL_W-1:0]    arb_idx;
  logic                preempt;

  rr_arb4 u_arb (
    .req   (REQ),
    .last  (last_q),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

`ifdef REFCLK_SEL_PREEMPT_EN
  localparam logic [HOLD_W-1:0] c_max_hold = HOLD_W'(MAX_HOLD_CYCLES);
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Counts owner cycles; the first ACTIVE cycle already reads 1.
  always_comb begin
    hold_d = HOLD_W'(1);
    if (state_q == ST_ACTIVE) begin
      hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) hold_q <= '0;
    else     hold_q <= hold_d;
  end

  assign preempt = (state_q == ST_ACTIVE) && (hold_q >= c_max_hold) &&
                   ((REQ & ~gnt_q) != '0);
`else
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD_CYCLES;
  assign preempt         = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_SEL;
          sel_d   = arb_idx;
          cnt_d   = c_settle;
        end
      end
      ST_SEL: begin
        // An abort wins over a settle expiry in the same cycle.
        if (!REQ[sel_q]) begin
          state_d = ST_RELEASE;
          cnt_d   = c_settle;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = ST_ACTIVE;
          last_d  = sel_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!REQ[sel_q] || preempt) begin
          state_d = ST_RELEASE;
          cnt_d   = c_settle;
        end
      end
      ST_RELEASE: begin
        if (cnt_q == CNT_W'(1)) state_d = ST_IDLE;
        else                    cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    ceb_d  = (state_d != ST_ACTIVE);
    gnt_d  = (state_d == ST_ACTIVE) ? (NUM_CH'(1) << sel_d) : '0;
    busy_d = (state_d == ST_SEL) || (state_d == ST_RELEASE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= SEL_W'(NUM_CH - 1);
      sel_q   <= '0;
      gnt_q   <= '0;
      ceb_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ceb_q   <= ceb_d;
      busy_q  <= busy_d;
    end
  end

  assign GNT          = gnt_q;
  assign RXRECCLK_SEL = sel_q;
  assign CEB          = ceb_q;
  assign BUSY         = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_refclk_out_sel_ctrl.sv
// ============================================================================
// tb_refclk_out_sel_ctrl : directed + random bench with a timestamp-based model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_refclk_out_sel_ctrl;

  localparam int S    = 4;
  localparam int MAXH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       ceb;
  logic       busy;

  always #5 clk = ~clk;

  refclk_out_sel_ctrl #(
    .SETTLE_CYCLES   (S),
    .MAX_HOLD_CYCLES (MAXH)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .REQ          (req),
    .GNT          (gnt),
    .RXRECCLK_SEL (sel),
    .CEB          (ceb),
    .BUSY         (busy)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Model: mode 0 idle, 1 selecting, 2 owner active, 3 releasing.
  // Timed phases end at an absolute edge number rather than via a counter.
  int cyc    = 0;
  int m_mode = 0;
  int m_sel  = 0;
  int m_last = 3;
  int m_tend = 0;
  int m_act  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h, expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] q, input int last);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (last + k) % 4;
      if (q[i]) return i;
    end
    return 0;
  endfunction

  task automatic model_edge(input logic r, input logic [3:0] q);
    logic [3:0] others;
    logic       pre;
    if (r) begin
      m_mode = 0; m_last = 3; m_sel = 0;
    end else begin
      case (m_mode)
        0: if (q != 4'b0) begin
             m_sel = rr_pick(q, m_last); m_mode = 1; m_tend = cyc + S;
           end
        1: if (!q[m_sel]) begin
             m_mode = 3; m_tend = cyc + S;
           end else if (cyc == m_tend) begin
             m_mode = 2; m_last = m_sel; m_act = cyc;
           end
        2: begin
             others = q & ~(4'b0001 << m_sel);
`ifdef REFCLK_SEL_PREEMPT_EN
             pre = (cyc - m_act >= MAXH) && (others != 4'b0);
`else
             pre = 1'b0;
`endif
             if (!q[m_sel] || pre) begin
               m_mode = 3; m_tend = cyc + S;
             end
           end
        default: if (cyc == m_tend) m_mode = 0;
      endcase
    end
  endtask

  task automatic step();
    logic [3:0] exp_gnt;
    @(posedge clk);
    cyc++;
    model_edge(rst, req);
    #1;
    exp_gnt = (m_mode == 2) ? 4'(1 << m_sel) : 4'b0000;
    check("ceb",  32'(ceb),  32'(m_mode != 2));
    check("gnt",  32'(gnt),  32'(exp_gnt));
    check("sel",  32'(sel),  32'(m_sel));
    check("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 3));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ceb"},  32'(ceb),  32'd1);
    check({tag, "_gnt"},  32'(gnt),  32'd0);
    check({tag, "_sel"},  32'(sel),  32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; step(); step();
    check_reset_vals("reset");
    rst = 1'b0;
  endtask

  initial begin
    int order[$];
    int run;
    int n01;
    int n10;
    logic [3:0] prev_gnt;

    do_reset();

    // Single grant on channel 2
    req = 4'b0100;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("sg_sel", 32'(sel), 32'd2);
      check("sg_busy", 32'(busy), 32'd1);
    end
    step();
    check("sg_gnt", 32'(gnt), 32'h4);
    check("sg_ceb", 32'(ceb), 32'd0);
    check("sg_busy_lo", 32'(busy), 32'd0);
    repeat (3) step();

    // Release
    req = 4'b0000;
    step();
    check("rel_gnt", 32'(gnt), 32'h0);
    check("rel_ceb", 32'(ceb), 32'd1);
    repeat (3) step();
    check("rel_busy", 32'(busy), 32'd1);
    step();
    check("rel_idle", 32'(busy), 32'd0);
    check("rel_sel", 32'(sel), 32'd2);

    // Abort during SEL: never granted
    req = 4'b0010;
    step();
    step();
    req = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort_gnt", 32'(gnt), 32'h0);
    end

    // Round-robin order from reset
    do_reset();
    req = 4'b1111;
    run = 0;
    prev_gnt = 4'b0;
    for (int i = 0; i < 500 && order.size() < 5; i++) begin
      step();
      if (gnt != 4'b0 && prev_gnt == 4'b0) begin
        for (int b = 0; b < 4; b++) if (gnt[b]) order.push_back(b);
      end
      prev_gnt = gnt;
      run = (gnt != 4'b0) ? run + 1 : 0;
      if (run == 10) begin
        req = 4'b1111 & ~gnt;
        step();
        prev_gnt = gnt;
        req = 4'b1111;
        run = 0;
      end
    end
    check("rr_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < order.size() && i < 5; i++) begin
      check("rr_order", 32'(order[i]), 32'(i % 4));
    end

    // Preemption scenario, then reset while an owner is active
    do_reset();
    req = 4'b0011;
    n01 = 0;
    n10 = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (gnt == 4'b0001) n01++;
      if (gnt == 4'b0010) n10++;
    end
`ifdef REFCLK_SEL_PREEMPT_EN
    check("pre_hold", 32'(n01), 32'(MAXH));
    check("pre_next", 32'(n10 > 0), 32'd1);
`else
    check("pre_hold", 32'(n01), 32'd36);
    check("pre_next", 32'(n10), 32'd0);
`endif
    check("midact_ceb", 32'(ceb), 32'd0);
    rst = 1'b1;
    step();
    check_reset_vals("midact");
    step();
    rst = 1'b0;

    // Random phase
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
